wavegen_multi: RTL and testbench

Parametrised, programmable periodic-waveform counter for the etch-a-sketch / display-driver datapath. Generalises the fixed 0..2^N-1 triangle counter with the following additions:
- programmable lower and upper bounds and step size;
- selectable mode: triangle, sawtooth up, sawtooth down, hold;
- a one-cycle period marker.
Output drives cursor sweeps, PWM reference ramps and test patterns.

---
 rtl/wavegen_pkg.sv | 19 +
 rtl/wavegen_multi_if.sv | 39 +++
 rtl/wavegen_step_calc.sv | 86 ++++++++
 rtl/wavegen_multi.sv | 109 ++++++++++
 tb/tb_wavegen_multi.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wavegen_pkg.sv
// wavegen_multi shared types: waveform mode, count direction
// and the optional period counter width (WAVEGEN_CYCLE_COUNT_EN).
package wavegen_pkg;

    typedef enum logic [1:0] {
        MODE_TRI      = 2'b00,
        MODE_SAW_UP   = 2'b01,
        MODE_SAW_DOWN = 2'b10,
        MODE_HOLD     = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int CYCLE_CNT_W = 16;

endpackage

// File: rtl/wavegen_multi_if.sv
// Config/status bundle for wavegen_multi.
// cycle_count exists only with WAVEGEN_CYCLE_COUNT_EN defined.
interface wavegen_multi_if #(
    parameter int N      = 8,
    parameter int STEP_W = 4
);
    import wavegen_pkg::*;

    logic              ena;
    logic              load;
    mode_t             cfg_mode;
    logic [N-1:0]      cfg_lo;
    logic [N-1:0]      cfg_hi;
    logic [STEP_W-1:0] cfg_step;
    logic [N-1:0]      out;
    logic              dir;
    logic              period_done;
    logic              cfg_err;
`ifdef WAVEGEN_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] cycle_count;
`endif

    modport master (
`ifdef WAVEGEN_CYCLE_COUNT_EN
        input  cycle_count,
`endif
        output ena, load, cfg_mode, cfg_lo, cfg_hi, cfg_step,
        input  out, dir, period_done, cfg_err
    );

    modport slave (
`ifdef WAVEGEN_CYCLE_COUNT_EN
        output cycle_count,
`endif
        input  ena, load, cfg_mode, cfg_lo, cfg_hi, cfg_step,
        output out, dir, period_done, cfg_err
    );

endinterface

// File: rtl/wavegen_step_calc.sv
// Next-value logic for wavegen_multi: N+1-bit add/subtract
// with borrow detect, clamping and wrap per mode.
module wavegen_step_calc
    import wavegen_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      i_out,
    input  dir_t              i_dir,
    input  logic [N-1:0]      i_lo,
    input  logic [N-1:0]      i_hi,
    input  logic [STEP_W-1:0] i_step,
    input  mode_t             i_mode,
    output logic [N-1:0]      o_next_out,
    output dir_t              o_next_dir,
    output logic              o_wrap
);
    localparam int PADW = N + 1 - STEP_W;

    logic [N:0] w_step;
    logic [N:0] w_up;
    logic [N:0] w_dn;
    logic [N:0] w_lo;
    logic [N:0] w_hi;
    logic       w_borrow;

    assign w_step   = {{PADW{1'b0}}, i_step};
    assign w_lo     = {1'b0, i_lo};
    assign w_hi     = {1'b0, i_hi};
    assign w_up     = {1'b0, i_out} + w_step;
    assign w_dn     = {1'b0, i_out} - w_step;
    assign w_borrow = w_dn[N];

    // Per-mode step; zero step and HOLD keep everything as is
    always_comb begin
        o_next_out = i_out;
        o_next_dir = i_dir;
        o_wrap     = 1'b0;
        if (i_step != '0) begin
            unique case (i_mode)
                MODE_TRI: begin
                    if (i_dir == DIR_UP) begin
                        if (w_up >= w_hi) begin
                            o_next_out = i_hi;
                            o_next_dir = DIR_DOWN;
                            o_wrap     = (i_lo == i_hi);
                        end else begin
                            o_next_out = w_up[N-1:0];
                        end
                    end else begin
                        if (w_borrow || w_dn <= w_lo) begin
                            o_next_out = i_lo;
                            o_next_dir = DIR_UP;
                            o_wrap     = 1'b1;
                        end else begin
                            o_next_out = w_dn[N-1:0];
                        end
                    end
                end
                MODE_SAW_UP: begin
                    o_next_dir = DIR_UP;
                    if (w_up > w_hi) begin
                        o_next_out = i_lo;
                        o_wrap     = 1'b1;
                    end else begin
                        o_next_out = w_up[N-1:0];
                    end
                end
                MODE_SAW_DOWN: begin
                    o_next_dir = DIR_DOWN;
                    if (w_borrow || w_dn < w_lo) begin
                        o_next_out = i_hi;
                        o_wrap     = 1'b1;
                    end else begin
                        o_next_out = w_dn[N-1:0];
                    end
                end
                MODE_HOLD: begin
                    o_next_out = i_out;
                end
            endcase
        end
    end

endmodule

// File: rtl/wavegen_multi.sv
// Programmable periodic waveform counter (tri/saw/hold).
// Option: WAVEGEN_CYCLE_COUNT_EN adds a 16-bit period counter.
module wavegen_multi
    import wavegen_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    wavegen_multi_if.slave  bus
);
    mode_t             r_mode;
    logic [N-1:0]      r_lo;
    logic [N-1:0]      r_hi;
    logic [STEP_W-1:0] r_step;
    logic [N-1:0]      r_out;
    dir_t              r_dir;
    logic              r_pd;
    logic              r_err;

    logic [N-1:0]      w_next_out;
    dir_t              w_next_dir;
    logic              w_wrap;
    logic              w_load_err;
    logic [N-1:0]      w_load_out;
    dir_t              w_load_dir;
    logic              w_adv;

    assign w_load_err = (bus.cfg_lo > bus.cfg_hi);
    assign w_load_out = (bus.cfg_mode == MODE_SAW_DOWN && !w_load_err)
                      ? bus.cfg_hi : bus.cfg_lo;
    assign w_load_dir = (bus.cfg_mode == MODE_SAW_DOWN) ? DIR_DOWN : DIR_UP;
    assign w_adv      = !bus.load && bus.ena && !r_err;

    wavegen_step_calc #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_calc (
        .i_out      (r_out),
        .i_dir      (r_dir),
        .i_lo       (r_lo),
        .i_hi       (r_hi),
        .i_step     (r_step),
        .i_mode     (r_mode),
        .o_next_out (w_next_out),
        .o_next_dir (w_next_dir),
        .o_wrap     (w_wrap)
    );

    // Shadow config; defaults reproduce the legacy 0..2^N-1 triangle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode <= MODE_TRI;
            r_lo   <= '0;
            r_hi   <= '1;
            r_step <= STEP_W'(1);
        end else if (bus.load) begin
            r_mode <= bus.cfg_mode;
            r_lo   <= bus.cfg_lo;
            r_hi   <= bus.cfg_hi;
            r_step <= bus.cfg_step;
        end
    end

    // Waveform state: load beats ena; an errored config freezes at lo
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out <= '0;
            r_dir <= DIR_UP;
            r_pd  <= 1'b0;
            r_err <= 1'b0;
        end else if (bus.load) begin
            r_out <= w_load_out;
            r_dir <= w_load_dir;
            r_pd  <= 1'b0;
            r_err <= w_load_err;
        end else if (w_adv) begin
            r_out <= w_next_out;
            r_dir <= w_next_dir;
            r_pd  <= w_wrap;
        end else begin
            r_pd  <= 1'b0;
        end
    end

    assign bus.out         = r_out;
    assign bus.dir         = r_dir;
    assign bus.period_done = r_pd;
    assign bus.cfg_err     = r_err;

`ifdef WAVEGEN_CYCLE_COUNT_EN
    logic [CYCLE_CNT_W-1:0] r_cnt;

    // Count periods in step with the period_done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (bus.load) begin
            r_cnt <= '0;
        end else if (w_adv && w_wrap) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.cycle_count = r_cnt;
`endif

endmodule

// File: tb/tb_wavegen_multi.sv
// Self-checking bench for wavegen_multi: directed sequences
// plus randomized traffic against an integer reference model.
module tb_wavegen_multi;
    import wavegen_pkg::*;

    localparam int N      = 8;
    localparam int STEP_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    int m_out, m_dir, m_pd, m_err;
    int m_mode, m_lo, m_hi, m_step, m_cnt;

    wavegen_multi_if #(.N(N), .STEP_W(STEP_W)) bus ();

    wavegen_multi #(.N(N), .STEP_W(STEP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: reset state of the waveform
    task automatic model_reset();
        m_mode = 0; m_lo = 0; m_hi = 255; m_step = 1;
        m_out = 0; m_dir = 1; m_pd = 0; m_err = 0; m_cnt = 0;
    endtask

    // Reference: one clock of behaviour in plain integer arithmetic
    task automatic model_clock();
        int up, dn;
        if (bus.load) begin
            m_mode = int'(bus.cfg_mode);
            m_lo   = int'(bus.cfg_lo);
            m_hi   = int'(bus.cfg_hi);
            m_step = int'(bus.cfg_step);
            m_err  = (m_lo > m_hi) ? 1 : 0;
            m_out  = (m_mode == 2 && m_err == 0) ? m_hi : m_lo;
            m_dir  = (m_mode == 2) ? 0 : 1;
            m_pd   = 0;
            m_cnt  = 0;
        end else if (bus.ena && m_err == 0 && m_step != 0 && m_mode != 3) begin
            up   = m_out + m_step;
            dn   = m_out - m_step;
            m_pd = 0;
            if (m_mode == 0) begin
                if (m_dir == 1) begin
                    if (up >= m_hi) begin
                        m_out = m_hi; m_dir = 0;
                        m_pd  = (m_lo == m_hi) ? 1 : 0;
                    end else m_out = up;
                end else begin
                    if (dn <= m_lo) begin
                        m_out = m_lo; m_dir = 1; m_pd = 1;
                    end else m_out = dn;
                end
            end else if (m_mode == 1) begin
                if (up > m_hi) begin m_out = m_lo; m_pd = 1; end
                else m_out = up;
            end else begin
                if (dn < m_lo) begin m_out = m_hi; m_pd = 1; end
                else m_out = dn;
            end
            if (m_pd == 1) m_cnt = (m_cnt + 1) % 65536;
        end else begin
            m_pd = 0;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int md, input int lo, input int hi, input int st);
        bus.cfg_mode = mode_t'(md[1:0]);
        bus.cfg_lo   = lo[N-1:0];
        bus.cfg_hi   = hi[N-1:0];
        bus.cfg_step = st[STEP_W-1:0];
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.ena = 1'b0; bus.load = 1'b0;
        bus.cfg_mode = MODE_TRI; bus.cfg_lo = '0;
        bus.cfg_hi = '0; bus.cfg_step = '0;
        apply_reset();
        checks++;
        if ({bus.out, bus.dir, bus.period_done, bus.cfg_err} !== {8'd0, 3'b100}) begin
            errors++;
            $display("FAIL reset: out=%0d dir=%0b pd=%0b err=%0b want 0 1 0 0",
                     bus.out, bus.dir, bus.period_done, bus.cfg_err);
        end
`ifdef WAVEGEN_CYCLE_COUNT_EN
        checks++;
        if (bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d want 0", bus.cycle_count);
        end
`endif
    endtask

    task automatic test_legacy_tri();
        int e, ed, ep;
        bus.ena = 1'b1;
        for (int k = 1; k <= 512; k++) begin
            tick();
            e  = (k <= 255) ? k : ((k <= 510) ? 510 - k : k - 510);
            ed = (k < 255 || k >= 510) ? 1 : 0;
            ep = (k == 510) ? 1 : 0;
            checks++;
            if (bus.out !== e[N-1:0] || bus.dir !== ed[0] || bus.period_done !== ep[0]) begin
                errors++;
                $display("FAIL legacy_tri k=%0d: out=%0d dir=%0b pd=%0b want %0d %0d %0d",
                         k, bus.out, bus.dir, bus.period_done, e, ed, ep);
            end
        end
    endtask

    task automatic test_tri_bounds();
        int exp_o [10];
        exp_o = '{10, 13, 16, 19, 20, 17, 14, 11, 10, 13};
        bus.ena = 1'b1;
        do_load(0, 10, 20, 3);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.out !== exp_o[i][N-1:0] || bus.period_done !== (i == 8)) begin
                errors++;
                $display("FAIL tri_bounds i=%0d: out=%0d pd=%0b want %0d %0b",
                         i, bus.out, bus.period_done, exp_o[i], (i == 8));
            end
        end
    endtask

    task automatic test_saw_up();
        int exp_o [4];
        exp_o = '{250, 254, 250, 254};
        bus.ena = 1'b1;
        do_load(1, 250, 255, 4);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.out !== exp_o[i][N-1:0] || bus.period_done !== (i == 2) || bus.dir !== 1'b1) begin
                errors++;
                $display("FAIL saw_up i=%0d: out=%0d pd=%0b dir=%0b want %0d %0b 1",
                         i, bus.out, bus.period_done, bus.dir, exp_o[i], (i == 2));
            end
        end
    endtask

    task automatic test_saw_down();
        int exp_o [5];
        exp_o = '{5, 3, 1, 5, 3};
        bus.ena = 1'b1;
        do_load(2, 0, 5, 2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.out !== exp_o[i][N-1:0] || bus.period_done !== (i == 3) || bus.dir !== 1'b0) begin
                errors++;
                $display("FAIL saw_down i=%0d: out=%0d pd=%0b dir=%0b want %0d %0b 0",
                         i, bus.out, bus.period_done, bus.dir, exp_o[i], (i == 3));
            end
        end
    endtask

    task automatic test_ena_err();
        int ena_pat [4];
        int exp_o [4];
        ena_pat = '{1, 0, 0, 1};
        exp_o   = '{5, 5, 5, 10};
        do_load(1, 0, 100, 5);
        for (int i = 0; i < 4; i++) begin
            bus.ena = ena_pat[i][0];
            tick();
            checks++;
            if (bus.out !== exp_o[i][N-1:0] || bus.period_done !== 1'b0) begin
                errors++;
                $display("FAIL ena_hold i=%0d: out=%0d pd=%0b want %0d 0",
                         i, bus.out, bus.period_done, exp_o[i]);
            end
        end
        bus.ena = 1'b1;
        do_load(0, 30, 20, 3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (bus.cfg_err !== 1'b1 || bus.out !== 8'd30 || bus.period_done !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err i=%0d: err=%0b out=%0d pd=%0b want 1 30 0",
                         i, bus.cfg_err, bus.out, bus.period_done);
            end
        end
        do_load(0, 0, 50, 7);
        tick();
        checks++;
        if (bus.cfg_err !== 1'b0 || bus.out !== 8'd7) begin
            errors++;
            $display("FAIL err_clear: err=%0b out=%0d want 0 7", bus.cfg_err, bus.out);
        end
    endtask

    task automatic test_lo_eq_hi();
        bus.ena = 1'b1;
        do_load(0, 42, 42, 3);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (bus.out !== 8'd42 || bus.period_done !== 1'b1 || bus.dir !== i[0] ^ 1'b1) begin
                errors++;
                $display("FAIL lo_eq_hi_tri i=%0d: out=%0d pd=%0b dir=%0b want 42 1 %0b",
                         i, bus.out, bus.period_done, bus.dir, i[0] ^ 1'b1);
            end
        end
        do_load(1, 7, 7, 2);
        tick();
        checks++;
        if (bus.out !== 8'd7 || bus.period_done !== 1'b1) begin
            errors++;
            $display("FAIL lo_eq_hi_saw: out=%0d pd=%0b want 7 1", bus.out, bus.period_done);
        end
        do_load(0, 0, 9, 0);
        tick();
        checks++;
        if (bus.out !== 8'd0 || bus.period_done !== 1'b0 || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL step_zero: out=%0d pd=%0b err=%0b want 0 0 0",
                     bus.out, bus.period_done, bus.cfg_err);
        end
    endtask

    task automatic test_async_reset();
        bus.ena = 1'b1;
        do_load(0, 0, 200, 10);
        repeat (30) tick();
        checks++;
        if (bus.out !== 8'd100 || bus.dir !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset: out=%0d dir=%0b want 100 0", bus.out, bus.dir);
        end
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.out !== 8'd0 || bus.dir !== 1'b1 || bus.period_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out=%0d dir=%0b pd=%0b want 0 1 0",
                     bus.out, bus.dir, bus.period_done);
        end
`ifdef WAVEGEN_CYCLE_COUNT_EN
        checks++;
        if (bus.cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_cnt: got %0d want 0", bus.cycle_count);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int a, b, t;
        logic [N+2:0] got, want;
        bus.ena = 1'b1;
        do_load(0, 0, 255, 1);
        for (int i = 0; i < 600; i++) begin
            bus.ena  = ($urandom_range(0, 3) != 0);
            bus.load = ($urandom_range(0, 15) == 0);
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if ($urandom_range(0, 7) != 0 && a > b) begin t = a; a = b; b = t; end
            if ($urandom_range(0, 9) == 0) b = a;
            bus.cfg_mode = mode_t'($urandom_range(0, 3));
            bus.cfg_lo   = a[N-1:0];
            bus.cfg_hi   = b[N-1:0];
            bus.cfg_step = STEP_W'($urandom_range(0, 15));
            tick();
            got  = {bus.out, bus.dir, bus.period_done, bus.cfg_err};
            want = {m_out[N-1:0], m_dir[0], m_pd[0], m_err[0]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random i=%0d: out/dir/pd/err=%0d/%0b/%0b/%0b want %0d/%0d/%0d/%0d",
                         i, bus.out, bus.dir, bus.period_done, bus.cfg_err,
                         m_out, m_dir, m_pd, m_err);
            end
`ifdef WAVEGEN_CYCLE_COUNT_EN
            checks++;
            if (bus.cycle_count !== m_cnt[15:0]) begin
                errors++;
                $display("FAIL random_cnt i=%0d: got %0d want %0d", i, bus.cycle_count, m_cnt);
            end
`endif
        end
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_legacy_tri();
        test_tri_bounds();
        test_saw_up();
        test_saw_down();
        test_ena_err();
        test_lo_eq_hi();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
